// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and memory-stage data access.
// Data has fixed priority; stallreq freezes the pipeline until all pending requesters are served.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        ice,
  input  logic [31:0] iaddr,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [3:0]  dre,
  input  logic [31:0] din,
  output logic [31:0] inst_o,
  output logic [31:0] dm_o,
  output logic        stallreq,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] INST = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       d_done;
  logic       i_done;
  logic [7:0] cnt;
  logic       d_pend;
  logic       i_pend;

  assign d_pend = dce & ~d_done;
  assign i_pend = ice & ~i_done;
  // Gated by reset so every output reads 0 while reset is held.
  assign stallreq = cpu_rst_n & (d_pend | i_pend);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= IDLE;
      d_done    <= 1'b0;
      i_done    <= 1'b0;
      cnt       <= 8'd0;
      inst_o    <= 32'd0;
      dm_o      <= 32'd0;
      bus_req   <= 1'b0;
      bus_addr  <= 32'd0;
      bus_we    <= 1'b0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      // Flags clear once the pipeline is released; completion below overrides.
      if (!stallreq) begin
        d_done <= 1'b0;
        i_done <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (d_pend) begin
            bus_addr  <= daddr;
            bus_we    <= |we;
            bus_be    <= we | dre;
            bus_wdata <= din;
            bus_req   <= 1'b1;
            state     <= DATA;
          end else if (i_pend) begin
            bus_addr  <= iaddr;
            bus_we    <= 1'b0;
            bus_be    <= 4'hF;
            bus_req   <= 1'b1;
            state     <= INST;
          end else begin
            bus_req <= 1'b0;
          end
        end
        DATA: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            cnt     <= 8'd0;
            d_done  <= 1'b1;
            if (!bus_we) dm_o <= bus_rdata;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            cnt     <= 8'd0;
            bus_err <= 1'b1;
            d_done  <= 1'b1;
            dm_o    <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        INST: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            cnt     <= 8'd0;
            i_done  <= 1'b1;
            inst_o  <= bus_rdata;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            cnt     <= 8'd0;
            bus_err <= 1'b1;
            i_done  <= 1'b1;
            inst_o  <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a short timeout of 4 cycles.
module tb_mem_port_arbiter;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        ice;
  logic [31:0] iaddr;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [3:0]  dre;
  logic [31:0] din;
  logic [31:0] inst_o;
  logic [31:0] dm_o;
  logic        stallreq;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst_n  (cpu_rst_n),
    .ice        (ice),
    .iaddr      (iaddr),
    .dce        (dce),
    .daddr      (daddr),
    .we         (we),
    .dre        (dre),
    .din        (din),
    .inst_o     (inst_o),
    .dm_o       (dm_o),
    .stallreq   (stallreq),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic i_ce, input logic [31:0] i_addr,
                               input logic d_ce, input logic [31:0] d_addr,
                               input logic [3:0] d_we, input logic [3:0] d_re,
                               input logic [31:0] d_in);
    ice   = i_ce;
    iaddr = i_addr;
    dce   = d_ce;
    daddr = d_addr;
    we    = d_we;
    dre   = d_re;
    din   = d_in;
    #1;
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, stallreq}, 32'd0);
    checkOutput("rst_dm_o", dm_o, 32'd0);
    checkOutput("rst_inst_o", inst_o, 32'd0);
    cpu_rst_n = 1'b1;
    tick();

    $display("[TB] reset mid-DATA");
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0040, 4'd0, 4'hF, 32'd0);
    checkOutput("t1_stall_pre", {31'd0, stallreq}, 32'd1);
    tick();
    checkOutput("t1_req", {31'd0, bus_req}, 32'd1);
    checkOutput("t1_addr", bus_addr, 32'h8000_0040);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    checkOutput("t1_rst_req", {31'd0, bus_req}, 32'd0);
    checkOutput("t1_rst_addr", bus_addr, 32'd0);
    checkOutput("t1_rst_be", {28'd0, bus_be}, 32'd0);
    checkOutput("t1_rst_stall", {31'd0, stallreq}, 32'd0);
    tick();
    cpu_rst_n = 1'b1;
    #1;
    tick();
    checkOutput("t1_reissue_req", {31'd0, bus_req}, 32'd1);
    checkOutput("t1_reissue_addr", bus_addr, 32'h8000_0040);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0;
    checkOutput("t1_dm_o", dm_o, 32'h1122_3344);
    checkOutput("t1_stall_end", {31'd0, stallreq}, 32'd0);
    checkOutput("t1_req_end", {31'd0, bus_req}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();

    $display("[TB] instruction fetch");
    applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();
    checkOutput("t2_req", {31'd0, bus_req}, 32'd1);
    checkOutput("t2_addr", bus_addr, 32'hBFC0_0000);
    checkOutput("t2_be", {28'd0, bus_be}, 32'hF);
    checkOutput("t2_we", {31'd0, bus_we}, 32'd0);
    checkOutput("t2_stall", {31'd0, stallreq}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h2401_0001;
    tick();
    bus_ack = 1'b0;
    checkOutput("t2_inst_o", inst_o, 32'h2401_0001);
    checkOutput("t2_stall_low", {31'd0, stallreq}, 32'd0);
    checkOutput("t2_req_low", {31'd0, bus_req}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();

    $display("[TB] byte store with wait states");
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0011, 4'b0100, 4'd0, 32'h00AB_0000);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) applyStimulus(1'b0, 32'd0, 1'b1, 32'h1234_5678, 4'b0001, 4'd0, 32'hFFFF_FFFF);
      checkOutput($sformatf("t3_req_c%0d", c), {31'd0, bus_req}, 32'd1);
      checkOutput($sformatf("t3_addr_c%0d", c), bus_addr, 32'h8000_0011);
      checkOutput($sformatf("t3_wdata_c%0d", c), bus_wdata, 32'h00AB_0000);
      checkOutput($sformatf("t3_be_c%0d", c), {28'd0, bus_be}, 32'h4);
      checkOutput($sformatf("t3_we_c%0d", c), {31'd0, bus_we}, 32'd1);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    checkOutput("t3_req_end", {31'd0, bus_req}, 32'd0);
    checkOutput("t3_dm_hold", dm_o, 32'h1122_3344);
    checkOutput("t3_no_err", {31'd0, bus_err}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();

    $display("[TB] data and fetch both pending");
    applyStimulus(1'b1, 32'hBFC0_0004, 1'b1, 32'h8000_0020, 4'd0, 4'hF, 32'd0);
    tick();
    checkOutput("t4_d_addr", bus_addr, 32'h8000_0020);
    checkOutput("t4_d_be", {28'd0, bus_be}, 32'hF);
    checkOutput("t4_stall_c1", {31'd0, stallreq}, 32'd1);
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    checkOutput("t4_dm_o", dm_o, 32'hCAFE_F00D);
    checkOutput("t4_idle_req", {31'd0, bus_req}, 32'd0);
    checkOutput("t4_stall_mid", {31'd0, stallreq}, 32'd1);
    tick();
    checkOutput("t4_i_req", {31'd0, bus_req}, 32'd1);
    checkOutput("t4_i_addr", bus_addr, 32'hBFC0_0004);
    checkOutput("t4_stall_c4", {31'd0, stallreq}, 32'd1);
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'h8C22_0000;
    tick();
    bus_ack = 1'b0;
    checkOutput("t4_inst_o", inst_o, 32'h8C22_0000);
    checkOutput("t4_stall_low", {31'd0, stallreq}, 32'd0);
    tick();
    checkOutput("t4_flags_clear", {31'd0, stallreq}, 32'd1);
    checkOutput("t4_no_reissue", {31'd0, bus_req}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();
    checkOutput("t4_idle", {31'd0, bus_req}, 32'd0);

    $display("[TB] timeout abort");
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0080, 4'd0, 4'hF, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("t5_req_c%0d", c), {31'd0, bus_req}, 32'd1);
      checkOutput($sformatf("t5_err_c%0d", c), {31'd0, bus_err}, 32'd0);
    end
    tick();
    checkOutput("t5_req_abort", {31'd0, bus_req}, 32'd0);
    checkOutput("t5_err_pulse", {31'd0, bus_err}, 32'd1);
    checkOutput("t5_dm_zero", dm_o, 32'd0);
    checkOutput("t5_stall_low", {31'd0, stallreq}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();
    checkOutput("t5_err_end", {31'd0, bus_err}, 32'd0);

    $display("[TB] back-to-back loads");
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0100, 4'd0, 4'hF, 32'd0);
    tick();
    checkOutput("t6_req1", {31'd0, bus_req}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'hA1A1_0001;
    tick();
    bus_ack = 1'b0;
    checkOutput("t6_dm1", dm_o, 32'hA1A1_0001);
    checkOutput("t6_stall1", {31'd0, stallreq}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0104, 4'd0, 4'hF, 32'd0);
    tick();
    checkOutput("t6_no_reissue", {31'd0, bus_req}, 32'd0);
    checkOutput("t6_stall2", {31'd0, stallreq}, 32'd1);
    tick();
    checkOutput("t6_req2", {31'd0, bus_req}, 32'd1);
    checkOutput("t6_addr2", bus_addr, 32'h8000_0104);
    bus_ack   = 1'b1;
    bus_rdata = 32'hA2A2_0002;
    tick();
    bus_ack = 1'b0;
    checkOutput("t6_dm2", dm_o, 32'hA2A2_0002);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();

    $display("[TB] empty enables and idle ack");
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_5555;
    tick();
    checkOutput("t7_idle_ack_req", {31'd0, bus_req}, 32'd0);
    checkOutput("t7_idle_ack_dm", dm_o, 32'hA2A2_0002);
    bus_ack = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0200, 4'd0, 4'd0, 32'd0);
    tick();
    checkOutput("t7_req", {31'd0, bus_req}, 32'd1);
    checkOutput("t7_be_zero", {28'd0, bus_be}, 32'd0);
    checkOutput("t7_we_zero", {31'd0, bus_we}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_0000;
    tick();
    bus_ack = 1'b0;
    checkOutput("t7_dm", dm_o, 32'h7777_0000);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
